// File: rtl/eth_phy_10g_rx_link_ctrl.sv
// rtl/eth_phy_10g_rx_link_ctrl.sv - 10G PHY RX link bring-up sequencer
module eth_phy_10g_rx_link_ctrl #(
   parameter int RESET_CYCLES   = 16,
   parameter int LOCK_TIMEOUT   = 1048576,
   parameter int UP_DEBOUNCE    = 1024,
   parameter int DOWN_DEBOUNCE  = 4,
   parameter int HOLDOFF_CYCLES = 4096
) (
   input  logic        clk,
   input  logic        i_rst_n,
   input  logic        i_cfg_enable,
   input  logic        i_rx_block_lock,
   input  logic        i_rx_high_ber,
   input  logic        i_serdes_rx_reset_req,
   output logic        o_serdes_rx_reset,
   output logic        o_datapath_rst,
   output logic        o_link_up,
   output logic [2:0]  o_state,
   output logic [7:0]  o_retry_count,
   output logic [15:0] o_link_drop_count
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RESET     = 3'd1,
      ST_WAIT_LOCK = 3'd2,
      ST_QUALIFY   = 3'd3,
      ST_LINK_UP   = 3'd4,
      ST_HOLDOFF   = 3'd5
   } state_t;

   // The single shared timer must reach the largest terminal count.
   localparam int MAX_A = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_B = (UP_DEBOUNCE > DOWN_DEBOUNCE) ? UP_DEBOUNCE : DOWN_DEBOUNCE;
   localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int MAXP  = (MAX_C > HOLDOFF_CYCLES) ? MAX_C : HOLDOFF_CYCLES;
   localparam int TW    = ($clog2(MAXP) < 1) ? 1 : $clog2(MAXP);

   localparam logic [TW-1:0] RST_LAST  = TW'(RESET_CYCLES - 1);
   localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_TIMEOUT - 1);
   localparam logic [TW-1:0] UP_LAST   = TW'(UP_DEBOUNCE - 1);
   localparam logic [TW-1:0] DOWN_LAST = TW'(DOWN_DEBOUNCE - 1);
   localparam logic [TW-1:0] HOLD_LAST = TW'(HOLDOFF_CYCLES - 1);

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [7:0]    retry_q, retry_d;
   logic [15:0]   drop_q, drop_d;
   logic          retry_inc, drop_inc, good;

   assign good = i_rx_block_lock && !i_rx_high_ber;

   // Next-state, timer and statistics decision.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q + 1'b1;
      retry_inc = 1'b0;
      drop_inc  = 1'b0;
      if (!i_cfg_enable) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_RESET;
            ST_RESET: begin
               if (timer_q == RST_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
               if (i_serdes_rx_reset_req) begin
                  state_d = ST_RESET;
               end else if (i_rx_block_lock) begin
                  state_d = ST_QUALIFY;
               end else if (timer_q == LOCK_LAST) begin
                  state_d   = ST_RESET;
                  retry_inc = 1'b1;
               end
            end
            ST_QUALIFY: begin
               if (i_serdes_rx_reset_req) begin
                  state_d = ST_RESET;
               end else if (!i_rx_block_lock) begin
                  state_d = ST_WAIT_LOCK;
               end else if (i_rx_high_ber) begin
                  timer_d = '0;
               end else if (timer_q == UP_LAST) begin
                  state_d = ST_LINK_UP;
               end
            end
            ST_LINK_UP: begin
               if (i_serdes_rx_reset_req) begin
                  state_d  = ST_RESET;
                  drop_inc = 1'b1;
               end else if (good) begin
                  timer_d = '0;
               end else if (timer_q == DOWN_LAST) begin
                  state_d  = ST_HOLDOFF;
                  drop_inc = 1'b1;
               end
            end
            ST_HOLDOFF: begin
               if (timer_q == HOLD_LAST) state_d = ST_RESET;
            end
            default: state_d = ST_IDLE;
         endcase
      end
      if (state_d != state_q) timer_d = '0;

      retry_d = retry_q;
      if (state_d == ST_LINK_UP && state_q != ST_LINK_UP) begin
         retry_d = '0;
      end else if (retry_inc && retry_q != 8'hFF) begin
         retry_d = retry_q + 8'd1;
      end

      drop_d = drop_q;
      if (drop_inc && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
   end

   // State, timer and counter registers.
   always_ff @(posedge clk) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         timer_q <= '0;
         retry_q <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         retry_q <= retry_d;
         drop_q  <= drop_d;
      end
   end

   assign o_serdes_rx_reset = (state_q == ST_RESET);
   assign o_datapath_rst    = (state_q == ST_IDLE) || (state_q == ST_RESET);
   assign o_link_up         = (state_q == ST_LINK_UP);
   assign o_state           = state_q;
   assign o_retry_count     = retry_q;
   assign o_link_drop_count = drop_q;

endmodule

// File: tb/tb_eth_phy_10g_rx_link_ctrl.sv
// tb/tb_eth_phy_10g_rx_link_ctrl.sv - directed bench for the RX link sequencer
module tb_eth_phy_10g_rx_link_ctrl;

   logic        clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_cfg_enable = 1'b0;
   logic        i_rx_block_lock = 1'b0;
   logic        i_rx_high_ber = 1'b0;
   logic        i_serdes_rx_reset_req = 1'b0;
   logic        o_serdes_rx_reset;
   logic        o_datapath_rst;
   logic        o_link_up;
   logic [2:0]  o_state;
   logic [7:0]  o_retry_count;
   logic [15:0] o_link_drop_count;

   int checks = 0;
   int errors = 0;

   localparam logic [2:0] S_IDLE = 3'd0, S_RESET = 3'd1, S_WAIT = 3'd2,
                          S_QUAL = 3'd3, S_UP = 3'd4, S_HOLD = 3'd5;

   eth_phy_10g_rx_link_ctrl #(
      .RESET_CYCLES(4), .LOCK_TIMEOUT(20), .UP_DEBOUNCE(8),
      .DOWN_DEBOUNCE(3), .HOLDOFF_CYCLES(5)
   ) dut (
      .clk(clk),
      .i_rst_n(i_rst_n),
      .i_cfg_enable(i_cfg_enable),
      .i_rx_block_lock(i_rx_block_lock),
      .i_rx_high_ber(i_rx_high_ber),
      .i_serdes_rx_reset_req(i_serdes_rx_reset_req),
      .o_serdes_rx_reset(o_serdes_rx_reset),
      .o_datapath_rst(o_datapath_rst),
      .o_link_up(o_link_up),
      .o_state(o_state),
      .o_retry_count(o_retry_count),
      .o_link_drop_count(o_link_drop_count)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset state
      tick(2);
      chk("rst_state", 16'(o_state), 16'(S_IDLE));
      chk("rst_dp_rst", 16'(o_datapath_rst), 16'd1);
      chk("rst_serdes", 16'(o_serdes_rx_reset), 16'd0);
      chk("rst_link_up", 16'(o_link_up), 16'd0);
      chk("rst_retry", 16'(o_retry_count), 16'd0);
      chk("rst_drop", o_link_drop_count, 16'd0);

      // 1: clean bring-up
      i_rst_n = 1'b1; i_cfg_enable = 1'b1; i_rx_block_lock = 1'b1;
      tick(1);
      chk("t1_reset_state", 16'(o_state), 16'(S_RESET));
      chk("t1_serdes_hi", 16'(o_serdes_rx_reset), 16'd1);
      tick(3);
      chk("t1_serdes_hi_4th", 16'(o_serdes_rx_reset), 16'd1);
      tick(1);
      chk("t1_wait_lock", 16'(o_state), 16'(S_WAIT));
      chk("t1_serdes_lo", 16'(o_serdes_rx_reset), 16'd0);
      chk("t1_dp_rst_lo", 16'(o_datapath_rst), 16'd0);
      tick(1);
      chk("t1_qualify", 16'(o_state), 16'(S_QUAL));
      tick(7);
      chk("t1_qualify_7", 16'(o_state), 16'(S_QUAL));
      tick(1);
      chk("t1_link_up_state", 16'(o_state), 16'(S_UP));
      chk("t1_link_up", 16'(o_link_up), 16'd1);
      chk("t1_retry", 16'(o_retry_count), 16'd0);

      // 3: lock-loss debounce
      i_rx_block_lock = 1'b0;
      tick(2);
      chk("t3_bad2_up", 16'(o_link_up), 16'd1);
      i_rx_block_lock = 1'b1;
      tick(1);
      chk("t3_recover_up", 16'(o_state), 16'(S_UP));
      i_rx_block_lock = 1'b0;
      tick(2);
      chk("t3_bad2b_up", 16'(o_state), 16'(S_UP));
      tick(1);
      chk("t3_holdoff", 16'(o_state), 16'(S_HOLD));
      chk("t3_drop1", o_link_drop_count, 16'd1);
      chk("t3_hold_link", 16'(o_link_up), 16'd0);
      chk("t3_hold_dp", 16'(o_datapath_rst), 16'd0);
      // 5: reset_req ignored in HOLDOFF and RESET
      i_serdes_rx_reset_req = 1'b1;
      tick(4);
      chk("t5_hold_ignore_req", 16'(o_state), 16'(S_HOLD));
      tick(1);
      chk("t3_hold_to_reset", 16'(o_state), 16'(S_RESET));
      tick(3);
      chk("t5_reset_ignore_req", 16'(o_state), 16'(S_RESET));
      i_serdes_rx_reset_req = 1'b0;
      tick(1);
      chk("t5_reset_done", 16'(o_state), 16'(S_WAIT));
      chk("t5_drop_still1", o_link_drop_count, 16'd1);

      // 2: lock timeouts
      tick(19);
      chk("t2_wait_19", 16'(o_state), 16'(S_WAIT));
      tick(1);
      chk("t2_timeout1", 16'(o_state), 16'(S_RESET));
      chk("t2_retry1", 16'(o_retry_count), 16'd1);
      tick(24);
      chk("t2_timeout2", 16'(o_state), 16'(S_RESET));
      chk("t2_retry2", 16'(o_retry_count), 16'd2);
      tick(24 * 300);
      chk("t2_timeout_n", 16'(o_state), 16'(S_RESET));
      chk("t2_retry_sat", 16'(o_retry_count), 16'd255);

      // 4: high_ber pulse during QUALIFY
      i_rx_block_lock = 1'b1;
      tick(4);
      chk("t4_wait", 16'(o_state), 16'(S_WAIT));
      tick(1);
      chk("t4_qualify", 16'(o_state), 16'(S_QUAL));
      tick(6);
      i_rx_high_ber = 1'b1;
      tick(1);
      chk("t4_ber_stay", 16'(o_state), 16'(S_QUAL));
      i_rx_high_ber = 1'b0;
      tick(7);
      chk("t4_after_ber_7", 16'(o_state), 16'(S_QUAL));
      tick(1);
      chk("t4_link_up", 16'(o_state), 16'(S_UP));
      chk("t4_retry_cleared", 16'(o_retry_count), 16'd0);

      // 5: reset_req in LINK_UP
      i_serdes_rx_reset_req = 1'b1;
      tick(1);
      chk("t5_req_reset", 16'(o_state), 16'(S_RESET));
      chk("t5_drop2", o_link_drop_count, 16'd2);
      i_serdes_rx_reset_req = 1'b0;

      // Timeout and lock on the same cycle: lock wins
      i_rx_block_lock = 1'b0;
      tick(4);
      chk("sim_wait", 16'(o_state), 16'(S_WAIT));
      tick(19);
      i_rx_block_lock = 1'b1;
      tick(1);
      chk("sim_lock_wins", 16'(o_state), 16'(S_QUAL));
      chk("sim_no_retry", 16'(o_retry_count), 16'd0);
      tick(8);
      chk("sim_up_again", 16'(o_state), 16'(S_UP));

      // Debounce completion and reset_req together: one increment
      i_rx_block_lock = 1'b0;
      tick(2);
      i_serdes_rx_reset_req = 1'b1;
      tick(1);
      chk("sim_both_reset", 16'(o_state), 16'(S_RESET));
      chk("sim_both_drop3", o_link_drop_count, 16'd3);
      i_serdes_rx_reset_req = 1'b0;

      // 6: disable from LINK_UP
      i_rx_block_lock = 1'b1;
      tick(4 + 1 + 8);
      chk("t6_up", 16'(o_state), 16'(S_UP));
      i_cfg_enable = 1'b0;
      tick(1);
      chk("t6_idle", 16'(o_state), 16'(S_IDLE));
      chk("t6_link_down", 16'(o_link_up), 16'd0);
      chk("t6_drop_hold", o_link_drop_count, 16'd3);
      chk("t6_dp_rst", 16'(o_datapath_rst), 16'd1);

      // 6: reset mid-QUALIFY
      i_cfg_enable = 1'b1;
      tick(1 + 4 + 1 + 3);
      chk("t6_mid_qual", 16'(o_state), 16'(S_QUAL));
      i_rst_n = 1'b0;
      tick(1);
      chk("t6_rst_idle", 16'(o_state), 16'(S_IDLE));
      chk("t6_rst_drop", o_link_drop_count, 16'd0);
      chk("t6_rst_retry", 16'(o_retry_count), 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
